// File: rtl/alu_seq_accum.sv
// Multi-cycle accumulator ALU: one op per valid/ready handshake, optional chaining on acc,
// iterative shift-add MUL over WIDTH cycles, per-op and sticky error reporting.
module alu_seq_accum #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic             chain,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             err,
    output logic             err_sticky,
    output logic             busy
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_SHL = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOT = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] res;
    } res_t;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  MUL_ITER  = CNTW'(WIDTH);

    // Single-cycle operations; MUL is handled by the iterative datapath instead.
    function automatic res_t alu_comb(input op_e op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        res_t           r;
        logic [WIDTH:0] sum;
        r.err = 1'b0;
        r.res = '0;
        sum   = '0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                r.res = sum[WIDTH-1:0];
                r.err = sum[WIDTH];
            end
            OP_SUB: begin
                r.res = a - b;
                r.err = (a < b);
            end
            OP_SHL:  r.res = (b >= SHIFT_LIM) ? '0 : (a << b);
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            OP_NOT:  r.res = ~a;
            default: r.res = '0;
        endcase
        return r;
    endfunction

    // An erroring op clears the accumulator instead of leaving a wrapped result.
    function automatic logic [WIDTH-1:0] err_clear(input logic e, input logic [WIDTH-1:0] res);
        return e ? '0 : res;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               sticky_q, sticky_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   opa;
    res_t               alu_r;
    logic [2*WIDTH-1:0] prod_step;
    logic               done;
    logic               done_err;
    logic [WIDTH-1:0]   done_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        vld_d     = 1'b0;
        err_d     = err_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        done_err  = 1'b0;
        done_res  = '0;
        opa       = chain ? acc_q : a_in;
        alu_r     = alu_comb(op_e'(opcode), opa, b_in);
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op_e'(opcode) == OP_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, opa};
                        mplier_d = b_in;
                        prod_d   = '0;
                        cnt_d    = MUL_ITER;
                    end else begin
                        done     = 1'b1;
                        done_err = alu_r.err;
                        done_res = alu_r.res;
                    end
                end
            end
            ST_MUL: begin
                // One multiplier bit per cycle; the last iteration writes the result.
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d  = ST_IDLE;
                    done     = 1'b1;
                    done_err = |prod_step[2*WIDTH-1:WIDTH];
                    done_res = prod_step[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            vld_d = 1'b1;
            err_d = done_err;
            acc_d = err_clear(done_err, done_res);
        end

        // A new error on the same edge as clr_sticky keeps the flag set.
        sticky_d = (done & done_err) | (sticky_q & ~clr_sticky);
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_MUL);
    assign acc        = acc_q;
    assign out_valid  = vld_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_alu_seq_accum.sv
// Directed bench for alu_seq_accum (WIDTH=16) with hand-computed expected values.
module tb_alu_seq_accum;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic         chain;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         clr_sticky;
    logic [W-1:0] acc;
    logic         out_valid;
    logic         err;
    logic         err_sticky;
    logic         busy;

    int n_chk = 0;
    int n_bad = 0;

    alu_seq_accum #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .chain      (chain),
        .a_in       (a_in),
        .b_in       (b_in),
        .clr_sticky (clr_sticky),
        .acc        (acc),
        .out_valid  (out_valid),
        .err        (err),
        .err_sticky (err_sticky),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic ch, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = 1'b1;
        opcode   = op;
        chain    = ch;
        a_in     = a;
        b_in     = b;
    endtask

    task automatic hold_off();
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
    endtask

    initial begin
        int ov_cnt;
        rst        = 1'b0;
        in_valid   = 1'b0;
        opcode     = 3'd0;
        chain      = 1'b0;
        a_in       = '0;
        b_in       = '0;
        clr_sticky = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_acc",    32'(acc), 32'h0);
        chk("rst_ov",     32'(out_valid), 32'h0);
        chk("rst_err",    32'(err), 32'h0);
        chk("rst_sticky", 32'(err_sticky), 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_ready",  32'(in_ready), 32'h1);
        rst = 1'b1;
        tick();

        // chained ADDs, back-to-back
        drive(3'd0, 1'b0, 16'h0003, 16'h0004);
        tick();
        chk("add1_acc", 32'(acc), 32'h0007);
        chk("add1_ov",  32'(out_valid), 32'h1);
        chk("add1_err", 32'(err), 32'h0);
        drive(3'd0, 1'b1, 16'hDEAD, 16'h0010);
        tick();
        chk("add2_acc", 32'(acc), 32'h0017);
        chk("add2_ov",  32'(out_valid), 32'h1);
        chk("add2_err", 32'(err), 32'h0);
        hold_off();
        tick();
        chk("idle_ov",  32'(out_valid), 32'h0);
        chk("idle_acc", 32'(acc), 32'h0017);

        // reset in the middle of a MUL
        drive(3'd2, 1'b0, 16'h0003, 16'h0005);
        tick();
        hold_off();
        repeat (4) tick();
        chk("mid_busy",  32'(busy), 32'h1);
        chk("mid_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("arst_acc",   32'(acc), 32'h0);
        chk("arst_busy",  32'(busy), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h1);
        chk("arst_ov",    32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ov_cnt = 0;
        repeat (20) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        chk("arst_noov",     32'(ov_cnt), 32'h0);
        chk("arst_acc_hold", 32'(acc), 32'h0);

        // ADD overflow, then AND, then sticky clear
        drive(3'd0, 1'b0, 16'hFFFF, 16'h0001);
        tick();
        chk("ovf_acc",    32'(acc), 32'h0);
        chk("ovf_err",    32'(err), 32'h1);
        chk("ovf_sticky", 32'(err_sticky), 32'h1);
        chk("ovf_ov",     32'(out_valid), 32'h1);
        drive(3'd4, 1'b0, 16'hF0F0, 16'h0FF0);
        tick();
        chk("and_acc",    32'(acc), 32'h00F0);
        chk("and_err",    32'(err), 32'h0);
        chk("and_sticky", 32'(err_sticky), 32'h1);
        hold_off();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'h0);
        chk("clr_ov",     32'(out_valid), 32'h0);

        // MUL with a request held during busy
        drive(3'd2, 1'b0, 16'h0012, 16'h0034);
        tick();
        drive(3'd0, 1'b0, 16'h0001, 16'h0001);
        ov_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mul_ready_%0d", i), 32'(in_ready), 32'h0);
            if (i == 8) chk("mul_acc_hold", 32'(acc), 32'h00F0);
            if (out_valid) ov_cnt++;
            tick();
        end
        chk("mul_early_ov", 32'(ov_cnt), 32'h0);
        chk("mul_acc",   32'(acc), 32'h03A8);
        chk("mul_ov",    32'(out_valid), 32'h1);
        chk("mul_err",   32'(err), 32'h0);
        chk("mul_ready", 32'(in_ready), 32'h1);
        chk("mul_busy",  32'(busy), 32'h0);
        tick();
        chk("held_acc", 32'(acc), 32'h0002);
        chk("held_ov",  32'(out_valid), 32'h1);
        hold_off();
        tick();
        chk("held_once_ov", 32'(out_valid), 32'h0);

        // MUL overflow and SUB borrow
        drive(3'd2, 1'b0, 16'h0100, 16'h0100);
        tick();
        hold_off();
        repeat (16) tick();
        chk("mulovf_acc",    32'(acc), 32'h0);
        chk("mulovf_err",    32'(err), 32'h1);
        chk("mulovf_ov",     32'(out_valid), 32'h1);
        chk("mulovf_sticky", 32'(err_sticky), 32'h1);
        drive(3'd0, 1'b0, 16'h0005, 16'h0005);
        tick();
        chk("add10_acc", 32'(acc), 32'h000A);
        chk("add10_err", 32'(err), 32'h0);
        drive(3'd1, 1'b0, 16'h0001, 16'h0002);
        tick();
        chk("sub_acc", 32'(acc), 32'h0);
        chk("sub_err", 32'(err), 32'h1);

        // shifts, logic ops, sticky set-vs-clear
        drive(3'd3, 1'b0, 16'h0001, 16'h000F);
        tick();
        chk("shl15_acc", 32'(acc), 32'h8000);
        chk("shl15_err", 32'(err), 32'h0);
        drive(3'd3, 1'b1, 16'h0000, 16'h0010);
        tick();
        chk("shl16_acc", 32'(acc), 32'h0);
        chk("shl16_err", 32'(err), 32'h0);
        drive(3'd7, 1'b0, 16'h00FF, 16'h1234);
        tick();
        chk("not_acc", 32'(acc), 32'hFF00);
        drive(3'd5, 1'b0, 16'hF000, 16'h000F);
        tick();
        chk("or_acc", 32'(acc), 32'hF00F);
        drive(3'd6, 1'b1, 16'h0000, 16'hFFFF);
        tick();
        chk("xor_acc", 32'(acc), 32'h0FF0);
        hold_off();
        clr_sticky = 1'b1;
        tick();
        chk("clr2_sticky", 32'(err_sticky), 32'h0);
        drive(3'd0, 1'b0, 16'hFFFF, 16'h0001);
        clr_sticky = 1'b1;
        tick();
        chk("setwins_sticky", 32'(err_sticky), 32'h1);
        chk("setwins_err",    32'(err), 32'h1);
        hold_off();
        tick();
        chk("errhold_ov",  32'(out_valid), 32'h0);
        chk("errhold_err", 32'(err), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
